lns_to_linear: RTL and testbench

- Converts one sign/log-magnitude LNS operand into a signed linear fixed-point value. The operand is the same format our log-domain adder produces: an 18-bit Q9.9 two's-complement log2 magnitude plus a separate sign bit.
- Uses the bit-shift (Mitchell) antilog approximation, 2^(e+f) ≈ (1+f)·2^e, so it is the decode end of the log-domain datapath.
- Iterative: the shift is done one bit per cycle.
- Valid/ready on both sides, so it sits between the log-domain arithmetic and linear-domain consumers.

---
 rtl/lns_pkg.sv | 34 +++
 rtl/lns_exp_decode.sv | 58 +++++
 rtl/lns_to_linear.sv | 133 +++++++++++++
 tb/tb_lns_to_linear.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lns_pkg.sv
// Shared LNS datapath constants: operand format, exact-zero code, FSM and shift-direction
// encodings, plus helpers that derive the exponent clamp bound and shift-counter width.
package lns_pkg;

  localparam int unsigned LOG_W  = 18;
  localparam int unsigned FRAC_W = 9;
  localparam int unsigned OUT_W  = 32;

  localparam logic [LOG_W-1:0] LNS_ZERO = {1'b1, {(LOG_W-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  typedef enum logic {
    DirLeft  = 1'b0,
    DirRight = 1'b1
  } dir_e;

  // Largest left-shift exponent that still fits 1.f into a signed OUT_W result.
  function automatic int lmax(input int unsigned out_w, input int unsigned frac_w);
    return int'(out_w) - int'(frac_w) - 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned out_w,
                                            input int unsigned frac_w);
    return $clog2(lmax(out_w, frac_w) + 1);
  endfunction

  localparam int LMAX = lmax(OUT_W, FRAC_W);

endpackage

// File: rtl/lns_exp_decode.sv
// Combinational exponent decode of a Q-format log2 magnitude: splits integer/fraction,
// applies the exact-zero, saturation and flush-to-zero clamps and sets up the shifter.
module lns_exp_decode #(
  parameter int unsigned LOG_W  = lns_pkg::LOG_W,
  parameter int unsigned FRAC_W = lns_pkg::FRAC_W,
  parameter int unsigned OUT_W  = lns_pkg::OUT_W,
  parameter int unsigned CNT_W  = lns_pkg::cnt_width(OUT_W, FRAC_W)
) (
  input  logic [LOG_W-1:0] in_log_i,
  output logic [OUT_W-2:0] mag_o,
  output logic [CNT_W-1:0] cnt_o,
  output lns_pkg::dir_e    dir_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             udf_o
);
  import lns_pkg::*;

  localparam int unsigned EXP_W = LOG_W - FRAC_W;
  localparam int unsigned MAG_W = OUT_W - 1;
  localparam logic signed [EXP_W-1:0] E_MAX = EXP_W'(lmax(OUT_W, FRAC_W));
  localparam logic signed [EXP_W-1:0] E_MIN = EXP_W'(-int'(FRAC_W));
  localparam logic [LOG_W-1:0] ZERO_CODE = {1'b1, {(LOG_W-1){1'b0}}};

  logic signed [EXP_W-1:0] e;
  logic signed [EXP_W-1:0] neg_e;
  logic [FRAC_W:0]         m;

  // Upper bits taken as signed are exactly floor(in_log / 2^FRAC_W).
  assign e     = signed'(in_log_i[LOG_W-1:FRAC_W]);
  assign neg_e = -e;
  assign m     = {1'b1, in_log_i[FRAC_W-1:0]};

  always_comb begin
    mag_o  = '0;
    cnt_o  = '0;
    dir_o  = DirLeft;
    zero_o = 1'b0;
    ovf_o  = 1'b0;
    udf_o  = 1'b0;
    if (in_log_i == ZERO_CODE) begin
      zero_o = 1'b1;
    end else if (e > E_MAX) begin
      ovf_o = 1'b1;
      mag_o = '1;
    end else if (e < E_MIN) begin
      udf_o = 1'b1;
    end else if (!e[EXP_W-1]) begin
      mag_o = MAG_W'(m);
      cnt_o = CNT_W'(e);
    end else begin
      mag_o = MAG_W'(m);
      cnt_o = CNT_W'(neg_e);
      dir_o = DirRight;
    end
  end

endmodule

// File: rtl/lns_to_linear.sv
// Sign/log-magnitude LNS to linear fixed-point converter using the Mitchell antilog,
// shifting one bit per cycle between valid/ready handshakes.
module lns_to_linear #(
  parameter int unsigned LOG_W  = lns_pkg::LOG_W,
  parameter int unsigned FRAC_W = lns_pkg::FRAC_W,
  parameter int unsigned OUT_W  = lns_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_W-1:0] in_log,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_udf
);
  import lns_pkg::*;

  localparam int unsigned MAG_W = OUT_W - 1;
  localparam int unsigned CNT_W = cnt_width(OUT_W, FRAC_W);

  state_e             state_q, state_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_udf_q, out_udf_d;

  logic [MAG_W-1:0]   dec_mag;
  logic [CNT_W-1:0]   dec_cnt;
  dir_e               dec_dir;
  logic               dec_zero, dec_ovf, dec_udf;
  logic [OUT_W-1:0]   mag_ext;

  lns_exp_decode #(
    .LOG_W  (LOG_W),
    .FRAC_W (FRAC_W),
    .OUT_W  (OUT_W),
    .CNT_W  (CNT_W)
  ) u_decode (
    .in_log_i (in_log),
    .mag_o    (dec_mag),
    .cnt_o    (dec_cnt),
    .dir_o    (dec_dir),
    .zero_o   (dec_zero),
    .ovf_o    (dec_ovf),
    .udf_o    (dec_udf)
  );

  assign mag_ext = {1'b0, mag_q};

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    data_d    = data_q;
    out_ovf_d = out_ovf_q;
    out_udf_d = out_udf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_d   = dec_mag;
          cnt_d   = dec_cnt;
          dir_d   = dec_dir;
          // Zero and flushed results must never come out as a negated pattern.
          sign_d  = in_sign & ~(dec_zero | dec_udf);
          ovf_d   = dec_ovf;
          udf_d   = dec_udf;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          mag_d = (dir_q == DirRight) ? {1'b0, mag_q[MAG_W-1:1]} : {mag_q[MAG_W-2:0], 1'b0};
        end else begin
          data_d    = sign_q ? -mag_ext : mag_ext;
          out_ovf_d = ovf_q;
          out_udf_d = udf_q;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mag_q     <= '0;
      cnt_q     <= '0;
      dir_q     <= DirLeft;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      data_q    <= '0;
      out_ovf_q <= 1'b0;
      out_udf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      data_q    <= data_d;
      out_ovf_q <= out_ovf_d;
      out_udf_q <= out_udf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = data_q;
  assign out_ovf   = out_ovf_q;
  assign out_udf   = out_udf_q;

endmodule

// File: tb/tb_lns_to_linear.sv
// Scoreboard bench for lns_to_linear: directed operands push hand-computed results,
// a monitor pops and compares on every output handshake.
module tb_lns_to_linear;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_log;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_udf;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        udf;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];

  lns_to_linear dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log    (in_log),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_udf   (out_udf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present an operand and, once accepted, record the expected response.
  task automatic send(input logic [17:0] lg, input logic s, input logic [31:0] d,
                      input logic o, input logic u, input int unsigned lat);
    exp_t   e;
    logic   done = 1'b0;
    @(negedge clk);
    in_log   = lg;
    in_sign  = s;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        e.data = d;
        e.ovf  = o;
        e.udf  = u;
        e.acc  = cyc;
        e.lat  = lat;
        sb.push_back(e);
        in_valid = 1'b0;
        done     = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compares each handshaken result against the scoreboard head.
  initial begin
    logic        prev_v = 1'b0;
    int unsigned t_valid = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) t_valid = cyc;
        prev_v = out_valid;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
            chk("out_udf", 32'(out_udf), 32'(e.udf));
            chk("latency", t_valid - e.acc, e.lat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_log    = '0;
    in_sign   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flags", {30'd0, out_ovf, out_udf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    send(18'h00000, 1'b0, 32'd512,        1'b0, 1'b0, 1);
    send(18'h00580, 1'b0, 32'd3584,       1'b0, 1'b0, 3);
    send(18'h00580, 1'b1, 32'hFFFFF200,   1'b0, 1'b0, 3);
    send(18'h3FE00, 1'b0, 32'd256,        1'b0, 1'b0, 2);
    send(18'h3FF00, 1'b1, 32'hFFFFFE80,   1'b0, 1'b0, 2);
    send(18'h3EC00, 1'b0, 32'd0,          1'b0, 1'b1, 1);
    send(18'h3EC00, 1'b1, 32'd0,          1'b0, 1'b1, 1);
    send(18'h02C00, 1'b0, 32'h7FFFFFFF,   1'b1, 1'b0, 1);
    send(18'h02C00, 1'b1, 32'h80000001,   1'b1, 1'b0, 1);
    send(18'h20000, 1'b1, 32'd0,          1'b0, 1'b0, 1);
    send(18'h3EFFF, 1'b0, 32'd1,          1'b0, 1'b0, 10);
    send(18'h02A00, 1'b0, 32'h40000000,   1'b0, 1'b0, 22);
    send(18'h02A00, 1'b1, 32'hC0000000,   1'b0, 1'b0, 22);
    send(18'h00001, 1'b0, 32'd513,        1'b0, 1'b0, 1);
    wait_idle();

    // Backpressure: result must hold and no second operand may slip in.
    out_ready = 1'b0;
    send(18'h00580, 1'b0, 32'd3584, 1'b0, 1'b0, 3);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) chk("bp_valid_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", out_data, 32'd3584);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      in_log   = 18'h00000;
      in_sign  = 1'b0;
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_data_after_hs", out_data, 32'd3584);
    wait_idle();

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_log   = 18'h02A00;
    in_sign  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_in_ready_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(18'h00000, 1'b0, 32'd512, 1'b0, 1'b0, 1);
    wait_idle();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
